// File: rtl/pulse_qualifier_pkg.sv
// Shared types and defaults for the pulse_qualifier slice: FSM state encoding,
// default parameter values and small elaboration-time helpers.
package pulse_qualifier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_QUAL = 2'd1,
    ST_HIGH = 2'd2,
    ST_DEAD = 2'd3
  } qual_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_WIDTH   = 3;
  localparam int DEF_DEAD_TIME   = 8;
  localparam int DEF_CNT_W       = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_qualifier_sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing an asynchronous level into the
// clk domain; clears to 0 on asynchronous active-low reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_r;

  // Shift the raw level through the chain; only the last stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= {STAGES{1'b0}};
    end else begin
      stage_r <= {stage_r[STAGES-2:0], d};
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/pulse_qualifier.sv
// pulse_qualifier: synchronizes a deglitched async level, qualifies its width,
// emits one Pulse per accepted event and enforces a dead time afterwards.
// Statistics counters are built only when PULSE_QUALIFIER_STATS_EN is defined.
module pulse_qualifier
  import pulse_qualifier_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_WIDTH   = DEF_MIN_WIDTH,
  parameter int DEAD_TIME   = DEF_DEAD_TIME,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset_b,
  input  logic             In,
  input  logic             Enable,
  input  logic             CntClear,
  output logic             Pulse,
  output logic             Level,
  output logic             Busy,
  output logic [CNT_W-1:0] AcceptCnt,
  output logic [CNT_W-1:0] RejectCnt
);

  localparam int WCNT_W = $clog2(max_int(MIN_WIDTH, DEAD_TIME) + 1);

  localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_MIN  = WCNT_W'(MIN_WIDTH);
  localparam logic [WCNT_W-1:0] WCNT_DEAD = WCNT_W'(DEAD_TIME);
  localparam logic              MIN_IS_ONE  = (MIN_WIDTH == 1);
  localparam logic              DEAD_IS_ZERO = (DEAD_TIME == 0);

  logic              sync_in_s;
  logic              accept_s;
  logic              reject_s;
  qual_state_e       state_r;
  logic [WCNT_W-1:0] cnt_r;
  logic              pulse_r;
  logic              level_r;
  logic              busy_r;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk   (Clk),
    .rst_n (Reset_b),
    .d     (In),
    .q     (sync_in_s)
  );

  // Accept/reject decisions for the coming edge, shared by FSM and counters.
  always_comb begin
    accept_s = 1'b0;
    reject_s = 1'b0;
    if (Enable) begin
      case (state_r)
        ST_IDLE: begin
          accept_s = sync_in_s & MIN_IS_ONE;
        end
        ST_QUAL: begin
          if (sync_in_s) begin
            accept_s = ((cnt_r + WCNT_ONE) == WCNT_MIN);
          end else begin
            reject_s = 1'b1;
          end
        end
        default: begin
          accept_s = 1'b0;
          reject_s = 1'b0;
        end
      endcase
    end else begin
      accept_s = 1'b0;
      reject_s = 1'b0;
    end
  end

  // Qualifier FSM with registered Pulse/Level/Busy; Enable low forces IDLE.
  always_ff @(posedge Clk or negedge Reset_b) begin
    if (!Reset_b) begin
      state_r <= ST_IDLE;
      cnt_r   <= WCNT_ZERO;
      pulse_r <= 1'b0;
      level_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (!Enable) begin
      state_r <= ST_IDLE;
      cnt_r   <= WCNT_ZERO;
      pulse_r <= 1'b0;
      level_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_HIGH;
            cnt_r   <= WCNT_ZERO;
            pulse_r <= 1'b1;
            level_r <= 1'b1;
            busy_r  <= 1'b1;
          end else if (sync_in_s) begin
            state_r <= ST_QUAL;
            cnt_r   <= WCNT_ONE;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
            level_r <= 1'b0;
          end
        end
        ST_QUAL: begin
          if (accept_s) begin
            state_r <= ST_HIGH;
            cnt_r   <= WCNT_ZERO;
            pulse_r <= 1'b1;
            level_r <= 1'b1;
          end else if (sync_in_s) begin
            cnt_r <= cnt_r + WCNT_ONE;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= WCNT_ZERO;
            busy_r  <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (!sync_in_s) begin
            level_r <= 1'b0;
            if (DEAD_IS_ZERO) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_DEAD;
              cnt_r   <= WCNT_DEAD;
            end
          end else begin
            level_r <= 1'b1;
          end
        end
        ST_DEAD: begin
          // The input is deliberately ignored until the dead time has elapsed.
          if (cnt_r == WCNT_ONE) begin
            state_r <= ST_IDLE;
            cnt_r   <= WCNT_ZERO;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - WCNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= WCNT_ZERO;
          pulse_r <= 1'b0;
          level_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Pulse = pulse_r;
  assign Level = level_r;
  assign Busy  = busy_r;

`ifdef PULSE_QUALIFIER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] acc_cnt_r;
  logic [CNT_W-1:0] rej_cnt_r;

  // Saturating event counters; a clear beats an increment on the same edge.
  always_ff @(posedge Clk or negedge Reset_b) begin
    if (!Reset_b) begin
      acc_cnt_r <= CNT_ZERO;
      rej_cnt_r <= CNT_ZERO;
    end else if (CntClear) begin
      acc_cnt_r <= CNT_ZERO;
      rej_cnt_r <= CNT_ZERO;
    end else begin
      if (accept_s && (acc_cnt_r != CNT_SAT)) begin
        acc_cnt_r <= acc_cnt_r + CNT_ONE;
      end else begin
        acc_cnt_r <= acc_cnt_r;
      end
      if (reject_s && (rej_cnt_r != CNT_SAT)) begin
        rej_cnt_r <= rej_cnt_r + CNT_ONE;
      end else begin
        rej_cnt_r <= rej_cnt_r;
      end
    end
  end

  assign AcceptCnt = acc_cnt_r;
  assign RejectCnt = rej_cnt_r;
`else
  logic unused_stats_s;

  assign unused_stats_s = CntClear ^ reject_s;
  assign AcceptCnt      = {CNT_W{1'b0}};
  assign RejectCnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pulse_qualifier.sv
// Bench for pulse_qualifier (defaults, CNT_W=2): vector table plus hand-written
// sequences; expected pulse cycles are queued and popped as pulses appear.
`timescale 1ns/1ps
module tb_pulse_qualifier;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int LAT     = 4;

  logic             clk;
  logic             rst_n;
  logic             in_l;
  logic             en;
  logic             clr;
  logic             pulse;
  logic             level;
  logic             busy;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] rej_cnt;

  pulse_qualifier #(
    .SYNC_STAGES (2),
    .MIN_WIDTH   (3),
    .DEAD_TIME   (8),
    .CNT_W       (CNT_W)
  ) dut (
    .Clk       (clk),
    .Reset_b   (rst_n),
    .In        (in_l),
    .Enable    (en),
    .CntClear  (clr),
    .Pulse     (pulse),
    .Level     (level),
    .Busy      (busy),
    .AcceptCnt (acc_cnt),
    .RejectCnt (rej_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    bit acc;
    bit rej;
  } vec_t;

  vec_t vecs[6];
  int   exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   acc_m;
  int   rej_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int exp_cnt(input int v);
`ifdef PULSE_QUALIFIER_STATS_EN
    return (v > CNT_MAX) ? CNT_MAX : v;
`else
    return 0;
`endif
  endfunction

  // One clock: cross the edge, then sample at the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (pulse === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_pulse", cyc, 32'hFFFF_FFFF);
      else check("pulse_cycle", cyc, exp_q.pop_front());
    end
  endtask

  task automatic pulse_in(input int hi, input int lo, input bit acc);
    if (acc) exp_q.push_back(cyc + 1 + LAT);
    in_l = 1'b1;
    repeat (hi) step();
    in_l = 1'b0;
    repeat (lo) step();
  endtask

  task automatic check_counts(input string name);
    check({name, "_acc"}, acc_cnt, exp_cnt(acc_m));
    check({name, "_rej"}, rej_cnt, exp_cnt(rej_m));
  endtask

  task automatic check_drain(input string name);
    check({name, "_missing_pulses"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    step();
    clr = 1'b0;
    acc_m = 0;
    rej_m = 0;
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0; acc_m = 0; rej_m = 0;
    rst_n = 1'b0; in_l = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_pulse", pulse, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check_counts("rst");

    // Width table: glitches rejected, MIN_WIDTH and longer accepted.
    vecs[0] = '{hi: 2,  lo: 20, acc: 1'b0, rej: 1'b1};
    vecs[1] = '{hi: 10, lo: 20, acc: 1'b1, rej: 1'b0};
    vecs[2] = '{hi: 1,  lo: 20, acc: 1'b0, rej: 1'b1};
    vecs[3] = '{hi: 3,  lo: 20, acc: 1'b1, rej: 1'b0};
    vecs[4] = '{hi: 4,  lo: 20, acc: 1'b1, rej: 1'b0};
    vecs[5] = '{hi: 2,  lo: 20, acc: 1'b0, rej: 1'b1};
    for (int i = 0; i < 6; i++) begin
      pulse_in(vecs[i].hi, vecs[i].lo, vecs[i].acc);
      acc_m += int'(vecs[i].acc);
      rej_m += int'(vecs[i].rej);
      check_counts($sformatf("vec%0d", i));
      check($sformatf("vec%0d_level", i), level, 0);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end
    check_drain("table");

    // Clean accept: Level window E0+4 .. E0+12, DEAD busy afterwards.
    clear_counts();
    exp_q.push_back(cyc + 1 + LAT);
    in_l = 1'b1;
    repeat (4) step();
    check("clean_level_early", level, 0);
    step();
    check("clean_level_rise", level, 1);
    repeat (5) step();
    in_l = 1'b0;
    repeat (2) step();
    check("clean_level_hold", level, 1);
    step();
    check("clean_level_fall", level, 0);
    check("clean_dead_busy", busy, 1);
    repeat (20) step();
    acc_m = 1;
    check_counts("clean");
    check("clean_idle_busy", busy, 0);
    check_drain("clean");

    // Dead-time suppression, then a gap long enough to accept.
    clear_counts();
    pulse_in(10, 3, 1'b1);
    pulse_in(4, 30, 1'b0);
    acc_m = 1;
    check_counts("dead_suppr");
    pulse_in(10, 12, 1'b1);
    pulse_in(4, 30, 1'b1);
    acc_m = 3;
    check_counts("dead_accept");
    check_drain("dead");

    // Enable abort during HIGH, then re-enable with In still high.
    clear_counts();
    exp_q.push_back(cyc + 1 + LAT);
    in_l = 1'b1;
    repeat (7) step();
    acc_m = 1;
    check("abort_level_before", level, 1);
    en = 1'b0;
    step();
    check("abort_level", level, 0);
    check("abort_busy", busy, 0);
    check_counts("abort");
    repeat (3) step();
    check("abort_busy_hold", busy, 0);
    en = 1'b1;
    exp_q.push_back(cyc + 1 + 2);
    repeat (3) step();
    check("reen_level", level, 1);
    check("reen_busy", busy, 1);
    in_l = 1'b0;
    repeat (20) step();
    acc_m = 2;
    check_counts("reen");
    check_drain("abort");

    // Saturation, then a clear landing on the same edge as an accept.
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      pulse_in(5, 20, 1'b1);
      acc_m++;
    end
    check_counts("sat");
    pulse_in(2, 20, 1'b0);
    rej_m = 1;
    check_counts("sat_rej");
    exp_q.push_back(cyc + 1 + LAT);
    in_l = 1'b1;
    repeat (4) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    acc_m = 0;
    rej_m = 0;
    check_counts("clr_coincident");
    repeat (5) step();
    in_l = 1'b0;
    repeat (20) step();
    check_counts("clr_after");
    check_drain("sat");

    // Asynchronous reset in HIGH, release with In held high.
    exp_q.push_back(cyc + 1 + LAT);
    in_l = 1'b1;
    repeat (7) step();
    check("pre_rst_level", level, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pulse", pulse, 0);
    check("arst_level", level, 0);
    check("arst_busy", busy, 0);
    check_counts("arst");
    repeat (2) step();
    rst_n = 1'b1;
    exp_q.push_back(cyc + 1 + LAT);
    repeat (4) step();
    check("rel_level_early", level, 0);
    step();
    check("rel_level", level, 1);
    in_l = 1'b0;
    repeat (20) step();
    acc_m = 1;
    check_counts("rel");
    check_drain("arst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_qualifier.md
# pulse_qualifier

Synchronous back end for the asynchronous delay-line deglitcher on emulator input lines (trigger/command strobes). Takes the stretched, still-asynchronous level, synchronizes it into the `Clk` domain, accepts it only if it stays high for a minimum number of cycles, and emits exactly one single-cycle `Pulse` per accepted event, followed by an enforced dead time. Optional saturating counters report accepted and rejected events for readback.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count, ≥2.
- `MIN_WIDTH`, default 3: consecutive synchronized-high cycles required to accept, ≥1.
- `DEAD_TIME`, default 8: cycles ignored after an accepted event ends, ≥0.
- `CNT_W`, default 16: statistics counter width.

Ports:
- `Clk` in 1: single clock.
- `Reset_b` in 1: reset, asynchronous, active-low.
- `In` in 1: asynchronous deglitched input level.
- `Enable` in 1: qualifier enable, synchronous to `Clk`.
- `CntClear` in 1: synchronous clear of both counters.
- `Pulse` out 1: one-cycle strobe per accepted event.
- `Level` out 1: filtered level, high from acceptance until the synchronized input falls.
- `Busy` out 1: high in every state except IDLE.
- `AcceptCnt` out CNT_W: accepted events, saturating.
- `RejectCnt` out CNT_W: rejected (too short) events, saturating.

## Operation
- `In` passes through `SYNC_STAGES` flops to give `sync_in`. The synchronizer runs regardless of `Enable`.
- FSM states: IDLE, QUAL, HIGH, DEAD. The width/dead counter is `$clog2(max(MIN_WIDTH,DEAD_TIME)+1)` bits.
- IDLE:
  - `sync_in`=1 and `Enable` → QUAL, count=1.
  - If `MIN_WIDTH`=1, go directly to HIGH with `Pulse`.
- QUAL:
  - `sync_in`=1 increments count.
  - When count reaches `MIN_WIDTH` → HIGH; `Pulse`=1 and `Level`=1 are registered on that edge; `AcceptCnt`++.
  - `sync_in`=0 first → IDLE; `RejectCnt`++.
- HIGH:
  - `Level` stays 1 while `sync_in`=1. `Pulse` is high for exactly one cycle.
  - `sync_in`=0 → DEAD with `Level`=0 and count loaded with `DEAD_TIME`.
  - If `DEAD_TIME`=0 → IDLE instead.
- DEAD:
  - Input is ignored and nothing is counted. Count decrements each cycle; at 1 → IDLE.
  - A still-high input at DEAD exit re-enters QUAL on the next edge as a new event.
- `Enable`=0 in any state: → IDLE on the next edge with `Level`=0. No pulse and no counter update. An aborted QUAL is not counted as a reject.
- Counters:
  - Saturate at all-ones.
  - `CntClear` clears both counters and wins over a simultaneous increment.

## Timing
- Reset values: `Pulse`=0, `Level`=0, `Busy`=0, `AcceptCnt`=0, `RejectCnt`=0. Synchronizer flops=0, FSM=IDLE.
- Reset asserted mid-event: outputs go to reset values immediately. After release the FSM starts in IDLE, so a held-high `In` is qualified afresh (full `SYNC_STAGES`+`MIN_WIDTH` latency).
- Latency: if `In` is first sampled high at edge E0, `Pulse` and `Level` are high after edge E0+`SYNC_STAGES`+`MIN_WIDTH`-1. With defaults this is E0+4.
- `Level` fall: `SYNC_STAGES` edges after `In` is first sampled low.
- Minimum accepted high time on `In`: `MIN_WIDTH` cycles (sampled).
- Minimum event spacing: accepted-event end to next acceptance ≥ `DEAD_TIME`+`MIN_WIDTH`+1 cycles.
- All outputs are registered; there is no combinational path from `In`.

## Configuration
- `PULSE_QUALIFIER_STATS_EN` defined: `AcceptCnt`/`RejectCnt` logic and `CntClear` are implemented as above.
- Not defined: the counters are not built, both count outputs are tied to 0, and `CntClear` is ignored. FSM, `Pulse`, `Level` and `Busy` are unchanged.

## Structure
- Shared package `pulse_qualifier_pkg`:
  - FSM state enum (IDLE, QUAL, HIGH, DEAD) with a 2-bit encoding.
  - Default parameter constants.
- One sub-module, `sync_chain`: a `SYNC_STAGES`-deep flop chain with asynchronous active-low reset to 0. It is reusable for other async emulator inputs.

## Test plan
- Glitch reject: `In` high for 2 cycles (defaults) → no `Pulse`, `Level` stays 0, `RejectCnt`=1, `AcceptCnt`=0.
- Clean accept: `In` high 10 cycles from E0 →
  - `Pulse` high for one cycle after E0+4.
  - `Level` high E0+4 to E0+12.
  - `AcceptCnt`=1.
- Dead-time suppression: accepted 10-cycle pulse, 3 low cycles, then a 4-cycle high → second event ignored, counters remain 1/0. The same with 12 low cycles → second event is accepted, `AcceptCnt`=2.
- Enable abort: drop `Enable` during HIGH → `Level`=0 next edge, FSM IDLE, `Busy`=0, no counter change. Re-enable while `In` is held high → new `Pulse` `MIN_WIDTH` cycles later.
- Saturation/clear (`CNT_W`=2):
  - 5 accepted events → `AcceptCnt`=3.
  - `CntClear` coincident with an accept `Pulse` → `AcceptCnt`=0.
  - Without `PULSE_QUALIFIER_STATS_EN` → both counts always 0.
- Async reset: assert `Reset_b` mid-HIGH → `Pulse`/`Level`/`Busy`/counts 0 immediately. Release with `In` held high → `Pulse` after 4 edges.
